// File: rtl/atm_pkg.sv
// Shared key codes, error codes and FSM state encoding for the ATM keypad entry block.
package atm_pkg;
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] KEY_CAN = 4'hF;

  localparam logic [7:0] ERR_NONE  = 8'h00;
  localparam logic [7:0] ERR_SHORT = 8'h10;
  localparam logic [7:0] ERR_OVF   = 8'h11;
  localparam logic [7:0] ERR_TMO   = 8'h12;

  localparam logic [2:0] PIN_DIGITS = 3'd4;
  localparam logic [2:0] AMT_DIGITS = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CONVERT, S_DONE} state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/atm_bcd_accum.sv
// Iterative BCD-to-binary converter: one digit per cycle, most significant first.
module atm_bcd_accum
  import atm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] digits,
  input  logic [2:0]  count,
  output logic [15:0] result,
  output logic        overflow,
  output logic        done
);
  logic        busy_q, busy_d;
  logic [2:0]  idx_q, idx_d;
  logic [17:0] acc_q, acc_d;
  logic [19:0] dig_q, dig_d;
  logic [4:0]  sh;
  logic [19:0] shifted;

  // idx counts remaining digits; the next digit sits at nibble idx-1
  assign sh      = {idx_q - 3'd1, 2'b00};
  assign shifted = dig_q >> sh;

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    dig_d  = dig_q;
    if (start) begin
      busy_d = 1'b1;
      idx_d  = count;
      acc_d  = '0;
      dig_d  = digits;
    end else if (busy_q) begin
      if (idx_q != 3'd0) begin
        acc_d = acc_q * 18'd10 + {14'd0, shifted[3:0]};
        idx_d = idx_q - 3'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      acc_q  <= '0;
      dig_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      dig_q  <= dig_d;
    end
  end

  assign done     = busy_q && (idx_q == 3'd0);
  assign result   = acc_q[15:0];
  assign overflow = |acc_q[17:16];
endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry: collects PIN or amount digits, edits, converts and reports errors.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        mode_amount,
  output logic        key_ready,
  output logic [15:0] pin_input,
  output logic        pin_valid,
  output logic [15:0] amount,
  output logic        amount_valid,
  output logic [2:0]  digit_count,
  output logic        cancel_pulse,
  output logic [7:0]  error_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [19:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d, tmr_nx;
  logic        rdy_q, rdy_d;
  logic [15:0] pin_q, pin_d, amt_q, amt_d;
  logic        pin_vld_q, pin_vld_d, amt_vld_q, amt_vld_d, can_q, can_d;
  logic [7:0]  err_q, err_d;
  logic        accept, acc_start, acc_ovf, acc_done;
  logic [15:0] acc_res;
  logic [2:0]  cap;

  assign accept = key_valid && rdy_q;
  assign tmr_nx = tmr_q + TW'(1);
  assign cap    = mode_q ? AMT_DIGITS : PIN_DIGITS;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    pin_d     = pin_q;
    amt_d     = amt_q;
    err_d     = err_q;
    pin_vld_d = 1'b0;
    amt_vld_d = 1'b0;
    can_d     = 1'b0;
    acc_start = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        err_d = ERR_NONE;
        if (is_digit(key_code)) begin
          state_d = S_COLLECT;
          mode_d  = mode_amount;
          buf_d   = {16'd0, key_code};
          cnt_d   = 3'd1;
          tmr_d   = '0;
        end else if (key_code == KEY_CAN) begin
          can_d = 1'b1;
        end
      end
      S_COLLECT: if (accept) begin
        err_d = ERR_NONE;
        tmr_d = '0;
        if (is_digit(key_code)) begin
          if (cnt_q < cap) begin
            buf_d = {buf_q[15:0], key_code};
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          case (key_code)
            KEY_CLR: begin
              buf_d = '0; cnt_d = '0; state_d = S_IDLE;
            end
            KEY_BS: if (cnt_q != 3'd0) begin
              buf_d = buf_q >> 4;
              cnt_d = cnt_q - 3'd1;
              if (cnt_q == 3'd1) state_d = S_IDLE;
            end
            KEY_ENT: begin
              buf_d = '0; cnt_d = '0;
              if (mode_q ? (cnt_q == 3'd0) : (cnt_q != PIN_DIGITS)) begin
                err_d   = ERR_SHORT;
                state_d = S_IDLE;
              end else if (mode_q) begin
                acc_start = 1'b1;
                state_d   = S_CONVERT;
              end else begin
                pin_d     = buf_q[15:0];
                pin_vld_d = 1'b1;
                state_d   = S_DONE;
              end
            end
            KEY_CAN: begin
              buf_d = '0; cnt_d = '0; can_d = 1'b1; state_d = S_IDLE;
            end
            default: ;
          endcase
        end
      end else begin
        tmr_d = tmr_nx;
        if (tmr_nx == TW'(TIMEOUT_CYCLES)) begin
          err_d = ERR_TMO; buf_d = '0; cnt_d = '0; tmr_d = '0; state_d = S_IDLE;
        end
      end
      S_CONVERT: if (acc_done) begin
        if (acc_ovf) begin
          err_d   = ERR_OVF;
          state_d = S_IDLE;
        end else begin
          amt_d     = acc_res;
          amt_vld_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      buf_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      rdy_q     <= 1'b1;
      pin_q     <= '0;
      amt_q     <= '0;
      err_q     <= ERR_NONE;
      pin_vld_q <= 1'b0;
      amt_vld_q <= 1'b0;
      can_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      rdy_q     <= rdy_d;
      pin_q     <= pin_d;
      amt_q     <= amt_d;
      err_q     <= err_d;
      pin_vld_q <= pin_vld_d;
      amt_vld_q <= amt_vld_d;
      can_q     <= can_d;
    end
  end

  atm_bcd_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .start    (acc_start),
    .digits   (buf_q),
    .count    (cnt_q),
    .result   (acc_res),
    .overflow (acc_ovf),
    .done     (acc_done)
  );

  assign key_ready    = rdy_q;
  assign pin_input    = pin_q;
  assign pin_valid    = pin_vld_q;
  assign amount       = amt_q;
  assign amount_valid = amt_vld_q;
  assign digit_count  = cnt_q;
  assign cancel_pulse = can_q;
  assign error_code   = err_q;
endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, idle cycles in COLLECT before entry is abandoned.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  key_code is valid this cycle.
REQ-005 SHALL have port key_code  input  4  0-9 digit, 0xA clear, 0xB backspace, 0xE enter, 0xF cancel; 0xC/0xD ignored.
REQ-006 SHALL have port mode_amount  input  1  0 = PIN entry, 1 = amount entry; sampled on first accepted key of an entry.
REQ-007 SHALL have port key_ready  output  1  high when a key is accepted this cycle; low in CONVERT and DONE.
REQ-008 SHALL have port pin_input  output  16  4-digit BCD PIN, first digit in [15:12]; held until the next PIN result.
REQ-009 SHALL have port pin_valid  output  1  one-cycle pulse with new pin_input.
REQ-010 SHALL have port amount  output  16  binary amount; held until the next amount result.
REQ-011 SHALL have port amount_valid  output  1  one-cycle pulse with new amount.
REQ-012 SHALL have port digit_count  output  3  digits currently buffered (0-5).
REQ-013 SHALL have port cancel_pulse  output  1  one-cycle pulse on cancel key.
REQ-014 SHALL have port error_code  output  8  0x00 none, 0x10 short entry, 0x11 overflow, 0x12 timeout; held until next accepted key.

Function
REQ-015 SHALL implement states IDLE, COLLECT, CONVERT, DONE.
REQ-016 IDLE: accepted digit -> COLLECT, latch mode, store digit, count = 1; non-digit keys other than cancel ignored.
REQ-017 COLLECT: digits shift into 20-bit BCD buffer (new digit at [3:0]); PIN mode caps at 4 digits, amount mode at 5; digits beyond the cap are ignored.
REQ-018 Backspace SHALL drop the last digit (shift right 4, count-1); count 1 -> IDLE; count 0 no effect.
REQ-019 Clear SHALL empty the buffer and return to IDLE without pulses or error.
REQ-020 Cancel in any state except CONVERT SHALL empty the buffer, pulse cancel_pulse next cycle, return to IDLE.
REQ-021 Enter in PIN mode with count = 4 SHALL load pin_input and pulse pin_valid the next cycle (DONE, then IDLE).
REQ-022 Enter with count < 4 (PIN) or count = 0 (amount) SHALL set error_code 0x10, clear buffer, return to IDLE.
REQ-023 Enter in amount mode SHALL go to CONVERT, processing one digit per cycle most-significant first: acc = acc*10 + digit in 18-bit arithmetic.
REQ-024 CONVERT result > 65535 SHALL set error_code 0x11, leave amount unchanged, no amount_valid, return to IDLE.
REQ-025 CONVERT success SHALL load amount and pulse amount_valid; latency enter-accept to pulse = count + 1 cycles.
REQ-026 Timeout counter SHALL reset on every accepted key and count in COLLECT only; reaching TIMEOUT_CYCLES sets error_code 0x12, clears buffer, returns to IDLE.
REQ-027 key_valid while key_ready is low SHALL be dropped, not queued.
REQ-028 mode_amount changes during COLLECT SHALL be ignored until the next entry.

Reset
REQ-029 rst SHALL force IDLE, buffer/count/timer 0, pin_input 0, amount 0, all pulses 0, error_code 0x00, key_ready 1 next cycle.
REQ-030 rst mid-COLLECT or mid-CONVERT SHALL abort without any valid pulse.

Structure
REQ-031 Key codes, error codes, and the state enum SHALL live in shared package atm_pkg.
REQ-032 The iterative BCD-to-binary accumulator SHALL be a sub-module atm_bcd_accum (start, digits, count in; result, overflow, done out).

Verification
REQ-033 Keys 1,2,3,4,E in PIN mode -> pin_input 0x1234, pin_valid one pulse the cycle after E.
REQ-034 Amount mode keys 6,5,5,3,5,E -> amount 0xFFFF after 6 cycles; 6,5,5,3,6,E -> error 0x11, no amount_valid.
REQ-035 PIN keys 1,2,B,7,8,9,E -> pin_input 0x1789; 1,2,E -> error 0x10.
REQ-036 Key 5 then no keys for TIMEOUT_CYCLES -> error 0x12, digit_count 0, IDLE.
REQ-037 rst asserted during CONVERT -> no amount_valid, all outputs at reset values next cycle.
REQ-038 Key 3 then F -> cancel_pulse for one cycle, digit_count 0, no valid pulses.
